cpu_clk_ctrl: RTL and testbench

//  Run/step/halt clock controller for the 12-bit CPU.
//  - Produces a one-cycle clock-enable pulse (cpu_tick) at a selectable decade rate, 1Hz..10MHz, from clock_50MHz.
//  - Replaces derived-clock muxing with enable strobes. Applies speed changes only at tick boundaries.
//  - Debounces front-panel run/step buttons. Sits between the board clock/buttons and the CPU core's enable input.

---
 rtl/cpu_clk_ctrl_pkg.sv | 16 +
 rtl/cpu_clk_ctrl_if.sv | 15 +
 rtl/cpu_clk_ctrl_decade_stage.sv | 16 +
 rtl/cpu_clk_ctrl.sv | 90 +++++++++
 tb/tb_cpu_clk_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_pkg: shared state encoding, rate codes and prescaler ratios for cpu_clk_ctrl.
package cpu_clk_pkg;
  typedef enum logic [1:0] {HALTED = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  typedef logic [2:0] speed_t;
  localparam speed_t SPD_1HZ = 3'd0;
  localparam speed_t SPD_10HZ = 3'd1;
  localparam speed_t SPD_100HZ = 3'd2;
  localparam speed_t SPD_1KHZ = 3'd3;
  localparam speed_t SPD_10KHZ = 3'd4;
  localparam speed_t SPD_100KHZ = 3'd5;
  localparam speed_t SPD_1MHZ = 3'd6;
  localparam speed_t SPD_10MHZ = 3'd7;
  localparam int FIRST_DIV = 5;
  localparam int DECADE_DIV = 10;
  localparam int NUM_STAGES = 8;
endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: front-panel/CPU-side signals of the clock controller.
interface cpu_clk_ctrl_if import cpu_clk_pkg::*; #(parameter int CNT_W = 16);
  speed_t speed_sel;
  logic run_btn;
  logic step_btn;
  logic cpu_halt;
  logic cpu_tick;
  logic running;
  speed_t speed_active;
  logic [CNT_W-1:0] tick_count;
  modport slave (input speed_sel, run_btn, step_btn, cpu_halt,
                 output cpu_tick, running, speed_active, tick_count);
  modport master (output speed_sel, run_btn, step_btn, cpu_halt,
                  input cpu_tick, running, speed_active, tick_count);
endinterface

// File: rtl/cpu_clk_ctrl_decade_stage.sv
// decade_stage: one prescaler stage, counts 0..N-1 while enabled and strobes on the last count.
module decade_stage #(parameter int N = 10) (
  input  logic clock_50MHz,
  input  logic reset_n,
  input  logic en_i,
  output logic strb_o
);
  logic [3:0] count_q, count_d;
  logic last;
  assign last = count_q == 4'(N - 1);
  assign strb_o = en_i & last;
  assign count_d = en_i ? (last ? 4'd0 : count_q + 4'd1) : count_q;
  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt controller issuing one-cycle CPU clock enables at a decade rate.
module cpu_clk_ctrl import cpu_clk_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 16
) (
  input logic clock_50MHz,
  input logic reset_n,
  cpu_clk_ctrl_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NUM_STAGES:0] chain;
  logic [NUM_STAGES-1:0] strb;
  logic rate_strb;
  assign chain[0] = 1'b1;
  // chain[1] is the 10MHz strobe; each later stage is one decade slower
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    decade_stage #(.N(g == 0 ? FIRST_DIV : DECADE_DIV)) u_stage (
      .clock_50MHz(clock_50MHz),
      .reset_n(reset_n),
      .en_i(chain[g]),
      .strb_o(chain[g+1])
    );
    assign strb[int'(SPD_10MHZ) - g] = chain[g+1];
  end
  speed_t speed_q;
  assign rate_strb = strb[speed_q];
  logic [1:0] btn_raw, evt;
  assign btn_raw = {bus.step_btn, bus.run_btn};
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic sync1_q, sync2_q, stable_q, evt_q;
    logic [DB_W-1:0] cnt_q;
    logic differ, done;
    assign differ = sync2_q != stable_q;
    assign done = cnt_q == DB_W'(DEBOUNCE_CYCLES - 1);
    assign evt[b] = evt_q;
    always_ff @(posedge clock_50MHz or negedge reset_n)
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        stable_q <= 1'b0;
        evt_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
        cnt_q <= (differ && !done) ? cnt_q + 1'b1 : '0;
        stable_q <= (differ && done) ? sync2_q : stable_q;
        evt_q <= differ & done & sync2_q;
      end
  end
  logic run_evt, step_evt;
  assign run_evt = evt[0];
  assign step_evt = evt[1];
  state_t state_q, state_d;
  logic running_q, tick;
  logic [CNT_W-1:0] count_q;
  always_comb begin
    state_d = state_q;
    tick = 1'b0;
    unique case (state_q)
      HALTED: state_d = run_evt ? RUN : step_evt ? STEP : HALTED;
      RUN: begin
        tick = rate_strb & ~bus.cpu_halt;
        state_d = (bus.cpu_halt | run_evt) ? HALTED : RUN;
      end
      STEP: begin
        tick = 1'b1;
        state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end
  // while running, a new rate only takes effect on a strobe of the old rate
  always_ff @(posedge clock_50MHz or negedge reset_n)
    if (!reset_n) begin
      state_q <= HALTED;
      running_q <= 1'b0;
      speed_q <= SPD_1HZ;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      running_q <= state_d == RUN;
      speed_q <= (state_q != RUN || rate_strb) ? bus.speed_sel : speed_q;
      count_q <= count_q + CNT_W'(tick);
    end
  assign bus.cpu_tick = tick;
  assign bus.running = running_q;
  assign bus.speed_active = speed_q;
  assign bus.tick_count = count_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed tests against a cycle-level behavioural model of the clock controller.
module tb_cpu_clk_ctrl;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;
  cpu_clk_ctrl_if #(.CNT_W(16)) bus();
  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clock_50MHz(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // model: time since reset in edges, tick rate as a plain period, buttons as raw sample history
  int m_cyc;
  bit m_run, m_step, m_revt, m_sevt, sb, t, r, s;
  bit m_lvl[2];
  bit m_evt[2];
  logic [2:0] m_spd;
  int m_count;
  logic [DB+1:0] hist[2];
  function automatic bit strobe(input int spd, input int c);
    int p = 5;
    for (int i = spd; i < 7; i++) p *= 10;
    return ((c + 1) % p) == 0;
  endfunction
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_tick", bus.cpu_tick, 0);
      chk("rst_running", bus.running, 0);
      chk("rst_speed", bus.speed_active, 0);
      chk("rst_count", bus.tick_count, 0);
      m_cyc = 0; m_run = 0; m_step = 0; m_revt = 0; m_sevt = 0;
      m_lvl = '{0, 0}; m_spd = 0; m_count = 0;
      hist[0] = '0; hist[1] = '0;
    end else begin
      sb = strobe(int'(m_spd), m_cyc);
      t = m_step | (m_run & sb & !bus.cpu_halt);
      chk("model_tick", bus.cpu_tick, t);
      chk("model_running", bus.running, m_run);
      chk("model_speed", bus.speed_active, m_spd);
      chk("model_count", bus.tick_count, m_count);
      m_count = (m_count + int'(t)) & 16'hFFFF;
      if (!m_run || sb) m_spd = bus.speed_sel;
      r = m_revt; s = m_sevt;
      if (m_step) m_step = 0;
      else if (m_run) begin if (bus.cpu_halt || r) m_run = 0; end
      else if (r) m_run = 1;
      else if (s) m_step = 1;
      hist[0] = {hist[0][DB:0], bus.run_btn};
      hist[1] = {hist[1][DB:0], bus.step_btn};
      for (int b = 0; b < 2; b++) begin
        m_evt[b] = 0;
        if (hist[b][DB+1:2] == {DB{~m_lvl[b]}}) begin
          m_lvl[b] = ~m_lvl[b];
          m_evt[b] = m_lvl[b];
        end
      end
      m_revt = m_evt[0]; m_sevt = m_evt[1];
      m_cyc++;
    end
  end
  int gaps[$];
  int n, pos, base;
  task automatic collect(input int cnt, input int budget);
    int last = -1;
    int c = 0;
    gaps.delete();
    while (gaps.size() < cnt && c < budget) begin
      @(negedge clk);
      if (bus.cpu_tick) begin
        gaps.push_back(last < 0 ? 0 : c - last);
        last = c;
      end
      c++;
    end
    chk("ticks_seen", gaps.size(), cnt);
    @(posedge clk); #1;
  endtask
  task automatic count_ticks(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (bus.cpu_tick) cnt++;
    end
    @(posedge clk); #1;
  endtask
  task automatic press(input bit step, input int hold);
    if (step) bus.step_btn = 1'b1; else bus.run_btn = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.step_btn = 1'b0;
    bus.run_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask
  task automatic align(input int md, input int rem);
    for (int i = 0; i < 200 && (m_cyc % md) != rem; i++) begin
      @(posedge clk); #1;
    end
    chk("align", m_cyc % md, rem);
  endtask
  initial begin
    bus.speed_sel = 3'b111;
    bus.run_btn = 1'b0;
    bus.step_btn = 1'b0;
    bus.cpu_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    count_ticks(2000, n);
    chk("t1_no_ticks", n, 0);
    chk("t1_running", bus.running, 0);
    chk("t1_count", bus.tick_count, 0);
    chk("t1_speed", bus.speed_active, 7);
    bus.run_btn = 1'b1;
    collect(20, 300);
    chk("t2_running", bus.running, 1);
    chk("t2_count", bus.tick_count, 20);
    for (int i = 1; i < 20 && i < gaps.size(); i++) chk("t2_gap", gaps[i], 5);
    bus.run_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_release_running", bus.running, 1);
    press(0, 10);
    chk("t2_halted", bus.running, 0);
    count_ticks(100, n);
    chk("t2_no_ticks", n, 0);
    press(0, 10);
    chk("t3_running", bus.running, 1);
    // switch just before a 10MHz strobe that coincides with a 1MHz strobe
    align(50, 47);
    bus.speed_sel = 3'b110;
    @(negedge clk);
    chk("t3_speed_before", bus.speed_active, 7);
    @(posedge clk); #1;
    collect(2, 200);
    if (gaps.size() == 2) chk("t3_gap", gaps[1], 50);
    chk("t3_speed_after", bus.speed_active, 6);
    press(0, 10);
    chk("t3_halted", bus.running, 0);
    bus.speed_sel = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    base = m_count;
    bus.step_btn = 1'b1;
    n = 0; pos = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.cpu_tick) begin n++; pos = k; end
    end
    @(posedge clk); #1;
    bus.step_btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t4_one_tick", n, 1);
    chk("t4_latency", pos, 8);
    chk("t4_count", bus.tick_count, (base + 1) & 16'hFFFF);
    chk("t4_halted", bus.running, 0);
    press(0, 10);
    chk("t5_running", bus.running, 1);
    align(5, 4);
    bus.cpu_halt = 1'b1;
    @(negedge clk);
    chk("t5_no_tick", bus.cpu_tick, 0);
    @(posedge clk); #1;
    bus.cpu_halt = 1'b0;
    chk("t5_halted", bus.running, 0);
    count_ticks(50, n);
    chk("t5_quiet", n, 0);
    bus.step_btn = 1'b1;
    count_ticks(30, n);
    bus.step_btn = 1'b0;
    chk("t5_step", n, 1);
    repeat (12) @(posedge clk);
    #1;
    press(0, 10);
    chk("t5_rerun", bus.running, 1);
    collect(3, 100);
    if (gaps.size() == 3) chk("t5_gap", gaps[2], 5);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_tick", bus.cpu_tick, 0);
    chk("t6_running", bus.running, 0);
    chk("t6_count", bus.tick_count, 0);
    chk("t6_speed", bus.speed_active, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    count_ticks(200, n);
    chk("t6_no_ticks", n, 0);
    chk("t6_count_after", bus.tick_count, 0);
    press(0, 10);
    chk("t6_running_again", bus.running, 1);
    collect(2, 100);
    if (gaps.size() == 2) chk("t6_gap", gaps[1], 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
